hour_counter: RTL and testbench

Hour stage of the clock datapath: consumes the minute stage's `min_carry` and keeps hours 0–23.
- Advances once per rising edge of `min_carry`.
- Raises a one-cycle `day_carry` on 23→0.
- Formats the count as BCD tens/ones in 24 h or 12 h form with a PM flag.
- Supports manual hour setting from a debounced push-button while `set_en` is asserted.

---
 rtl/hour_counter.sv | 172 +++++++++++++++++
 tb/tb_hour_counter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hour_counter.sv
// Hour stage of the clock datapath: counts hours 0..23 from the minute
// carry and shows the count as BCD in 24 h or 12 h form with a PM flag.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a new button level is accepted
//   RESET_HOUR       hour count loaded on reset (0..23)
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   min_carry  minute-stage carry; counts on its rising edge only
//   set_en     1 = time-set mode (button steps hours, carry ignored)
//   btn_inc    raw bouncy increment button, active-high
//   mode_12h   1 = 12-hour display
//   hour_tens  BCD tens of the displayed hour (registered)
//   hour_ones  BCD ones of the displayed hour (registered)
//   pm         1 when the hour count is 12 or more (registered)
//   day_carry  one-cycle pulse on a 23 -> 0 rollover in run mode

module hour_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESET_HOUR      = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       min_carry,
  input  logic       set_en,
  input  logic       btn_inc,
  input  logic       mode_12h,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic       pm,
  output logic       day_carry
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    RST_H   = 5'(RESET_HOUR);

  logic [4:0]    hours;
  logic          min_carry_prev;
  logic          btn_s1;
  logic          btn_s2;
  logic          btn_db;
  logic          btn_db_prev;
  logic [CW-1:0] db_cnt;

  logic       adv;
  logic       press;
  logic       db_diff;
  logic       at_top;
  logic [4:0] hours_nxt;

  assign adv     = min_carry & ~min_carry_prev;
  assign press   = btn_db & ~btn_db_prev;
  assign db_diff = btn_s2 ^ btn_db;
  assign at_top  = (hours >= 5'd23);

  always_comb begin
    hours_nxt = hours + 5'd1;
    if (at_top) begin
      hours_nxt = 5'd0;
    end
  end

  // Minute carry edge detector; tracks the input in both modes so a
  // carry already high when set mode ends is not seen as a new edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_carry_prev <= 1'b0;
    end else begin
      min_carry_prev <= min_carry;
    end
  end

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_inc;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: the synchronized level must differ from the accepted
  // level for DEBOUNCE_CYCLES consecutive edges to be taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt      <= '0;
      btn_db      <= 1'b0;
      btn_db_prev <= 1'b0;
    end else begin
      btn_db_prev <= btn_db;
      if (!db_diff) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        btn_db <= btn_s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Hour count and rollover pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours     <= RST_H;
      day_carry <= 1'b0;
    end else begin
      day_carry <= 1'b0;
      unique case (1'b1)
        set_en: begin
          if (press) begin
            hours <= hours_nxt;
          end
        end
        default: begin
          if (adv) begin
            hours     <= hours_nxt;
            day_carry <= at_top;
          end
        end
      endcase
    end
  end

  // Display formatting.
  logic [4:0] disp_h;
  logic [3:0] tens_c;
  logic [3:0] ones_c;

  always_comb begin
    disp_h = hours;
    if (mode_12h) begin
      if (hours >= 5'd12) begin
        disp_h = hours - 5'd12;
      end
      if (disp_h == 5'd0) begin
        disp_h = 5'd12;
      end
    end
  end

  always_comb begin
    tens_c = 4'd0;
    ones_c = 4'(disp_h);
    if (disp_h >= 5'd20) begin
      tens_c = 4'd2;
      ones_c = 4'(disp_h - 5'd20);
    end else if (disp_h >= 5'd10) begin
      tens_c = 4'd1;
      ones_c = 4'(disp_h - 5'd10);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour_tens <= 4'd0;
      hour_ones <= 4'd0;
      pm        <= 1'b0;
    end else begin
      hour_tens <= tens_c;
      hour_ones <= ones_c;
      pm        <= (hours >= 5'd12);
    end
  end

endmodule

// File: tb/tb_hour_counter.sv
// Directed bench for hour_counter with DEBOUNCE_CYCLES=4.
// Two instances share stimulus: reset hour 0 and reset hour 23.

module tb_hour_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic min_carry = 1'b0;
  logic set_en = 1'b0;
  logic btn_inc = 1'b0;
  logic mode_12h = 1'b0;

  logic [3:0] t0, o0, t23, o23;
  logic       pm0, pm23, dc0, dc23;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hour_counter #(.DEBOUNCE_CYCLES(4), .RESET_HOUR(0)) dut0 (
    .clk(clk), .reset(reset), .min_carry(min_carry),
    .set_en(set_en), .btn_inc(btn_inc), .mode_12h(mode_12h),
    .hour_tens(t0), .hour_ones(o0), .pm(pm0), .day_carry(dc0)
  );

  hour_counter #(.DEBOUNCE_CYCLES(4), .RESET_HOUR(23)) dut23 (
    .clk(clk), .reset(reset), .min_carry(min_carry),
    .set_en(set_en), .btn_inc(btn_inc), .mode_12h(mode_12h),
    .hour_tens(t23), .hour_ones(o23), .pm(pm23), .day_carry(dc23)
  );

  // Packs {tens, ones, pm, day_carry} for compact comparisons.
  function automatic logic [9:0] pk(input logic [3:0] t,
                                    input logic [3:0] o,
                                    input logic p, input logic d);
    return {t, o, p, d};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    min_carry = 1'b0;
    set_en = 1'b0;
    btn_inc = 1'b0;
    mode_12h = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      min_carry = 1'b1;
      step(1);
      min_carry = 1'b0;
      step(1);
    end
  endtask

  task automatic test_reset();
    logic [9:0] e;
    @(negedge clk);
    reset = 1'b1;
    step(2);
    e = pk(4'd0, 4'd0, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL in_reset_h0 got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL in_reset_h23 got=%h want=%h",
               pk(t23, o23, pm23, dc23), e);
      bad++;
    end
    reset = 1'b0;
    step(1);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL post_reset_h0 got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    e = pk(4'd2, 4'd3, 1'b1, 1'b0);
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL post_reset_h23 got=%h want=%h",
               pk(t23, o23, pm23, dc23), e);
      bad++;
    end
  endtask

  task automatic test_held_carry();
    logic [9:0] e;
    int n;
    do_reset();
    pulse_min(9);
    e = pk(4'd0, 4'd9, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL held_pre got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    min_carry = 1'b1;
    step(5);
    min_carry = 1'b0;
    step(2);
    e = pk(4'd1, 4'd0, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL held_once got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    // Held carry across 23 -> 0 gives a single day pulse.
    do_reset();
    n = 0;
    min_carry = 1'b1;
    repeat (5) begin
      step(1);
      if (dc23) n++;
    end
    min_carry = 1'b0;
    step(2);
    total++;
    if (n !== 1) begin
      $display("FAIL held_day_width got=%0d want=1", n);
      bad++;
    end
    e = pk(4'd0, 4'd0, 1'b0, 1'b0);
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL held_wrap got=%h want=%h",
               pk(t23, o23, pm23, dc23), e);
      bad++;
    end
  endtask

  task automatic test_rollover();
    logic [9:0] e;
    do_reset();
    min_carry = 1'b1;
    step(1);
    e = pk(4'd2, 4'd3, 1'b1, 1'b1);
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL roll_edge got=%h want=%h",
               pk(t23, o23, pm23, dc23), e);
      bad++;
    end
    total++;
    if (dc0 !== 1'b0) begin
      $display("FAIL roll_h0_dc got=%b want=0", dc0);
      bad++;
    end
    min_carry = 1'b0;
    step(1);
    e = pk(4'd0, 4'd0, 1'b0, 1'b0);
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL roll_after got=%h want=%h",
               pk(t23, o23, pm23, dc23), e);
      bad++;
    end
  endtask

  task automatic test_12h();
    logic [9:0] e;
    do_reset();
    mode_12h = 1'b1;
    step(1);
    e = pk(4'd1, 4'd2, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL h12_0 got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    e = pk(4'd1, 4'd1, 1'b1, 1'b0);
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL h12_23 got=%h want=%h", pk(t23, o23, pm23, dc23), e);
      bad++;
    end
    pulse_min(12);
    e = pk(4'd1, 4'd2, 1'b1, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL h12_12 got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    pulse_min(1);
    e = pk(4'd0, 4'd1, 1'b1, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL h12_13 got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    mode_12h = 1'b0;
    step(1);
    e = pk(4'd1, 4'd3, 1'b1, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL h24_13 got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    e = pk(4'd1, 4'd2, 1'b1, 1'b0);
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL h24_wrap12 got=%h want=%h",
               pk(t23, o23, pm23, dc23), e);
      bad++;
    end
  endtask

  task automatic test_set_mode();
    logic [9:0] e;
    int n;
    do_reset();
    set_en = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      btn_inc = 1'b1;
      step(w);
      btn_inc = 1'b0;
      step(8);
    end
    e = pk(4'd0, 4'd0, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL bounce got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    // Stable press: display changes 2 + 4 + 1 + 1 edges after press.
    n = 0;
    btn_inc = 1'b1;
    repeat (7) begin
      step(1);
      if (dc23) n++;
    end
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL press_early got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    repeat (3) begin
      step(1);
      if (dc23) n++;
    end
    btn_inc = 1'b0;
    repeat (10) begin
      step(1);
      if (dc23) n++;
    end
    e = pk(4'd0, 4'd1, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL press_once got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    e = pk(4'd0, 4'd0, 1'b0, 1'b0);
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL press_wrap got=%h want=%h",
               pk(t23, o23, pm23, dc23), e);
      bad++;
    end
    total++;
    if (n !== 0) begin
      $display("FAIL press_wrap_dc got=%0d want=0", n);
      bad++;
    end
    pulse_min(3);
    e = pk(4'd0, 4'd1, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL set_carry got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    // Carry rising while in set mode is dropped, not deferred.
    min_carry = 1'b1;
    step(1);
    set_en = 1'b0;
    step(2);
    min_carry = 1'b0;
    step(2);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL set_drop got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    pulse_min(1);
    e = pk(4'd0, 4'd2, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL run_resume got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(10);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL run_btn got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [9:0] e;
    do_reset();
    set_en = 1'b1;
    btn_inc = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    e = pk(4'd0, 4'd0, 1'b0, 1'b0);
    total++;
    if (pk(t23, o23, pm23, dc23) !== e) begin
      $display("FAIL mid_rst_out got=%h want=%h",
               pk(t23, o23, pm23, dc23), e);
      bad++;
    end
    reset = 1'b0;
    step(7);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL mid_rst_early got=%h want=%h",
               pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    step(1);
    e = pk(4'd0, 4'd1, 1'b0, 1'b0);
    total++;
    if (pk(t0, o0, pm0, dc0) !== e) begin
      $display("FAIL mid_rst_inc got=%h want=%h", pk(t0, o0, pm0, dc0), e);
      bad++;
    end
    btn_inc = 1'b0;
    set_en = 1'b0;
    step(10);
  endtask

  initial begin
    test_reset();
    test_held_carry();
    test_rollover();
    test_12h();
    test_set_mode();
    test_reset_mid_debounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
